// File: rtl/mult_div_seq.sv
// Iterative radix-2 multiply/divide sequencer with start/done handshake.
// Signed operands are processed as magnitudes and sign-corrected in a final FIX cycle.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               op_r;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic               div0_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               start_div0;
  logic               last_step;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH:0]     div_rem_nx;
  logic [2*WIDTH-1:0] div_acc_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign start_div0 = start && op && (b == '0);
  assign last_step  = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = start_div0 ? DONE : RUN;
      RUN:  if (last_step) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand magnitudes and one radix-2 step of each datapath
  always_comb begin
    mag_a      = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b      = (is_signed && b[WIDTH-1]) ? -b : b;

    mul_addend = acc[0] ? opb : '0;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_acc_nx = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: remainder shifts in the next dividend bit, quotient bit enters acc LSB
    div_sh     = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_ge     = rem[WIDTH] || (div_sh >= {1'b0, opb});
    div_rem_nx = div_ge ? (div_sh - {1'b0, opb}) : div_sh;
    div_acc_nx = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};

    prod_fix   = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix    = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_r   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      div0_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (start_div0) begin
              div0_r <= 1'b1;
            end else begin
              op_r   <= op;
              sign_a <= is_signed && a[WIDTH-1];
              sign_b <= is_signed && b[WIDTH-1];
              cnt    <= '0;
              rem    <= '0;
              if (op) begin
                opb <= mag_b;
                acc <= {{WIDTH{1'b0}}, mag_a};
              end else begin
                opb <= mag_a;
                acc <= {{WIDTH{1'b0}}, mag_b};
              end
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_r) begin
            acc <= div_acc_nx;
            rem <= div_rem_nx;
          end else begin
            acc <= mul_acc_nx;
          end
        end
        FIX: begin
          if (op_r) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
        end
        DONE: div0_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);
  assign div0 = div0_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq (WIDTH=32): directed table, corner sequences,
// and random operations against a 64-bit arithmetic reference model.
module tb_mult_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op, is_signed;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div0;

  int total = 0;
  int bad   = 0;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         o;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         ed0;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic o, input logic s, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic [W-1:0] ph,
                                input logic [W-1:0] pl, output logic [W-1:0] eh,
                                output logic [W-1:0] el, output logic ed0);
    longint sx, sy, q, r;
    logic [63:0] p;
    ed0 = 1'b0;
    eh  = ph;
    el  = pl;
    sx  = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy  = s ? longint'($signed(y)) : longint'({32'b0, y});
    if (!o) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else if (y == '0) begin
      ed0 = 1'b1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  // Called just after a posedge; returns with the DUT back in IDLE.
  task automatic do_op(input logic o, input logic s, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input int glitch_at,
                       output int lat, output int pulses, output logic [W-1:0] rh,
                       output logic [W-1:0] rl, output logic rd0, output int busy_bad);
    logic exp_busy;
    op = o; is_signed = s; a = aa; b = bb; start = 1'b1;
    lat = -1; pulses = 0; busy_bad = 0; rh = '0; rl = '0; rd0 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n + 1 == glitch_at) begin
        start = 1'b1; op = 1'b1; a = 32'd5; b = '0;
      end else begin
        start = 1'b0;
      end
      exp_busy = (o && bb == '0) ? 1'b0 : (n <= W + 1);
      if (busy !== exp_busy) busy_bad++;
      if (lat > 0 && n == lat + 1) chk("div0_clear", {63'b0, div0}, 64'd0);
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = n; rh = hi; rl = lo; rd0 = div0;
        end
      end
      if (lat > 0 && n >= lat + 2) break;
    end
  endtask

  task automatic run_check(input string nm, input logic o, input logic s,
                           input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic ed0, input int glitch_at);
    int lat, pulses, busy_bad;
    logic [W-1:0] rh, rl;
    logic rd0;
    do_op(o, s, aa, bb, glitch_at, lat, pulses, rh, rl, rd0, busy_bad);
    chk({nm, "_lat"},    lat,      ed0 ? 64'd1 : 64'(W + 2));
    chk({nm, "_pulses"}, pulses,   64'd1);
    chk({nm, "_hi"},     rh,       eh);
    chk({nm, "_lo"},     rl,       el);
    chk({nm, "_div0"},   rd0,      ed0);
    chk({nm, "_busy"},   busy_bad, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ph, pl, eh, el, ra, rb;
    logic ed0, ro, rs;
    int dones;

    reset = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0, 0);
    chk("rst_hi",   hi,   0);
    chk("rst_lo",   lo,   0);
    reset = 1'b0;

    vt.push_back('{1'b0, 1'b1, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0});
    vt.push_back('{1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vt.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0});
    vt.push_back('{1'b0, 1'b0, 32'h80000000, 32'd2,        32'h1,        32'h0,        1'b0});
    vt.push_back('{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vt.push_back('{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'd5,        32'd9,        32'd5,        32'h0,        1'b0});
    vt.push_back('{1'b1, 1'b1, 32'd0,        32'd5,        32'h0,        32'h0,        1'b0});
    vt.push_back('{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h56781234, 32'h10000,    32'h1234,     32'h5678,     1'b0});
    vt.push_back('{1'b1, 1'b1, 32'd3,        32'd0,        32'h1234,     32'h5678,     1'b1});

    foreach (vt[i]) run_check($sformatf("vec%0d", i), vt[i].o, vt[i].s, vt[i].a, vt[i].b,
                              vt[i].eh, vt[i].el, vt[i].ed0, 0);

    // start pulsed during RUN must be ignored
    run_check("ignore", 1'b0, 1'b1, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 10);
    ph = 32'h0; pl = 32'h2A;

    for (int i = 0; i < 30; i++) begin
      ro = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      ra = $urandom;
      rb = ($urandom_range(7) == 0) ? 32'h0 :
           ($urandom_range(3) == 0) ? W'($urandom_range(20)) : $urandom;
      model(ro, rs, ra, rb, ph, pl, eh, el, ed0);
      run_check($sformatf("rnd%0d", i), ro, rs, ra, rb, eh, el, ed0, 0);
      ph = eh; pl = el;
    end

    // reset in the middle of an operation aborts it
    op = 1'b0; is_signed = 1'b1; a = 32'd7; b = 32'd6; start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (n == 14) reset = 1'b1;
    end
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi",   hi,   0);
    chk("abort_lo",   lo,   0);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("abort_nodone", dones, 0);
    model(1'b0, 1'b0, 32'd1000, 32'd1000, 32'h0, 32'h0, eh, el, ed0);
    run_check("after_abort", 1'b0, 1'b0, 32'd1000, 32'd1000, eh, el, ed0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
